// File: rtl/abus_wrr_arbiter_pkg.sv
// abus_wrr_arbiter shared types: FSM state encoding and width helpers.
package abus_wrr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int MID_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmr_w(input int t);
    return (t > 1) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/abus_wrr_arbiter_pick.sv
// abus_rr_pick: combinational round-robin search, first requester
// at or after ptr_i with wrap; returns one-hot pick and its index.
module abus_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int   j;
    logic found;
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/abus_wrr_arbiter.sv
// abus_wrr_arbiter: registered weighted round-robin arbiter with
// grant locking and a per-transaction timeout watchdog.
module abus_wrr_arbiter
  import abus_wrr_arbiter_pkg::*;
#(
  parameter int NB_MASTER    = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                              abus_clk,
  input  logic                              abus_rstb,
  input  logic [NB_MASTER-1:0]              abus_mreq,
  input  logic                              abus_sack,
  input  logic [NB_MASTER*WEIGHT_WIDTH-1:0] cfg_weight,
  output logic [NB_MASTER-1:0]              abus_mgrant,
  output logic                              abus_tabort,
  output logic                              timeout_irq,
  output logic [MID_W-1:0]                  timeout_mid
);

  localparam int IW = idx_w(NB_MASTER);
  localparam int TW = tmr_w(TIMEOUT);
  localparam int WW = WEIGHT_WIDTH;

  arb_state_e           state_q, state_d;
  logic [NB_MASTER-1:0] grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [WW-1:0]        credit_q, credit_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 irq_q, irq_d;
  logic [MID_W-1:0]     mid_q, mid_d;

  logic [NB_MASTER-1:0] pick0, pick1;
  logic [IW-1:0]        pidx0, pidx1;
  logic [IW-1:0]        nptr;
  logic [NB_MASTER-1:0] req_oth;
  logic                 req_cur;

  assign nptr    = (idx_q == IW'(NB_MASTER - 1)) ? '0 : idx_q + 1'b1;
  assign req_oth = abus_mreq & ~grant_q;
  assign req_cur = |(abus_mreq & grant_q);

  abus_rr_pick #(.N(NB_MASTER), .IW(IW)) u_pick_idle (
    .req_i  (abus_mreq),
    .ptr_i  (ptr_q),
    .pick_o (pick0),
    .idx_o  (pidx0)
  );

  abus_rr_pick #(.N(NB_MASTER), .IW(IW)) u_pick_ack (
    .req_i  (req_oth),
    .ptr_i  (nptr),
    .pick_o (pick1),
    .idx_o  (pidx1)
  );

  // Zero weight still grants one transaction per turn.
  function automatic logic [WW-1:0] wt(input logic [IW-1:0] i);
    logic [WW-1:0] w;
    w = cfg_weight[int'(i)*WW +: WW];
    return (w == '0) ? WW'(1) : w;
  endfunction

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    irq_d    = 1'b0;
    mid_d    = mid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|abus_mreq) begin
          grant_d  = pick0;
          idx_d    = pidx0;
          credit_d = wt(pidx0);
          timer_d  = '0;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (abus_sack) begin
          timer_d = '0;
          if (credit_q > WW'(1) && req_cur) begin
            credit_d = credit_q - 1'b1;
          end else begin
            ptr_d = nptr;
            if (|req_oth) begin
              grant_d  = pick1;
              idx_d    = pidx1;
              credit_d = wt(pidx1);
            end else begin
              grant_d  = '0;
              credit_d = '0;
              state_d  = ST_IDLE;
            end
          end
        end else if (!req_cur) begin
          grant_d  = '0;
          ptr_d    = nptr;
          credit_d = '0;
          timer_d  = '0;
          state_d  = ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ABORT: begin
        grant_d  = '0;
        ptr_d    = nptr;
        credit_d = '0;
        timer_d  = '0;
        irq_d    = 1'b1;
        mid_d    = MID_W'(idx_q);
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      timer_q  <= '0;
      irq_q    <= 1'b0;
      mid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
      irq_q    <= irq_d;
      mid_q    <= mid_d;
    end
  end

  assign abus_mgrant = grant_q;
  assign abus_tabort = (state_q == ST_ABORT);
  assign timeout_irq = irq_q;
  assign timeout_mid = mid_q;

endmodule

// File: tb/tb_abus_wrr_arbiter.sv
// Directed bench for abus_wrr_arbiter (NB_MASTER=4, TIMEOUT=8).
module tb_abus_wrr_arbiter;

  logic        abus_clk;
  logic        abus_rstb;
  logic [3:0]  abus_mreq;
  logic        abus_sack;
  logic [15:0] cfg_weight;
  logic [3:0]  abus_mgrant;
  logic        abus_tabort;
  logic        timeout_irq;
  logic [2:0]  timeout_mid;

  int pass_cnt;
  int total_cnt;

  abus_wrr_arbiter #(
    .NB_MASTER    (4),
    .WEIGHT_WIDTH (4),
    .TIMEOUT      (8)
  ) dut (
    .abus_clk    (abus_clk),
    .abus_rstb   (abus_rstb),
    .abus_mreq   (abus_mreq),
    .abus_sack   (abus_sack),
    .cfg_weight  (cfg_weight),
    .abus_mgrant (abus_mgrant),
    .abus_tabort (abus_tabort),
    .timeout_irq (timeout_irq),
    .timeout_mid (timeout_mid)
  );

  initial abus_clk = 1'b0;
  always #5 abus_clk = ~abus_clk;

  task automatic tick();
    @(posedge abus_clk);
    #1;
  endtask

  task automatic do_reset();
    abus_rstb = 1'b0;
    abus_mreq = '0;
    abus_sack = 1'b0;
    repeat (2) @(posedge abus_clk);
    #1;
    abus_rstb = 1'b1;
  endtask

  task automatic test_reset();
    abus_rstb  = 1'b0;
    abus_mreq  = '0;
    abus_sack  = 1'b0;
    cfg_weight = 16'h1111;
    #2;
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq, timeout_mid} !== 9'b0)
      $display("FAIL reset_outputs: got %b/%b/%b/%0d want 0/0/0/0",
               abus_mgrant, abus_tabort, timeout_irq, timeout_mid);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (abus_mgrant !== 4'b0000)
      $display("FAIL reset_idle_grant: got %b want 0000", abus_mgrant);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    cfg_weight = 16'h1111;
    abus_mreq  = 4'b0101;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        total_cnt++;
        if (abus_mgrant !== exp_g[i])
          $display("FAIL basic_grant%0d_c%0d: got %b want %b",
                   i, c, abus_mgrant, exp_g[i]);
        else pass_cnt++;
        abus_sack = (c == 2);
        tick();
      end
      abus_sack = 1'b0;
    end
    abus_mreq = '0;
  endtask

  task automatic test_weight();
    logic [3:0] exp_g [8];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
              4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    cfg_weight = 16'h0013;
    abus_mreq  = 4'b0011;
    abus_sack  = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (abus_mgrant !== exp_g[i])
        $display("FAIL weight_turn%0d: got %b want %b",
                 i, abus_mgrant, exp_g[i]);
      else pass_cnt++;
      tick();
    end
    abus_sack = 1'b0;
    abus_mreq = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_weight = 16'h1111;
    abus_mreq  = 4'b1100;
    tick();
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if ({abus_mgrant, abus_tabort, timeout_irq} !== 6'b0100_00)
        $display("FAIL timeout_wait_c%0d: got g=%b ab=%b irq=%b want 0100/0/0",
                 k, abus_mgrant, abus_tabort, timeout_irq);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq} !== 6'b0100_10)
      $display("FAIL timeout_abort_c8: got g=%b ab=%b irq=%b want 0100/1/0",
               abus_mgrant, abus_tabort, timeout_irq);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq, timeout_mid} !== 9'b0000_01_010)
      $display("FAIL timeout_irq_c9: got g=%b ab=%b irq=%b mid=%0d want 0000/0/1/2",
               abus_mgrant, abus_tabort, timeout_irq, timeout_mid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({abus_mgrant, timeout_irq, timeout_mid} !== 8'b1000_0_010)
      $display("FAIL timeout_next_c10: got g=%b irq=%b mid=%0d want 1000/0/2",
               abus_mgrant, timeout_irq, timeout_mid);
    else pass_cnt++;
    abus_mreq = '0;
  endtask

  task automatic test_simul();
    logic seen;
    do_reset();
    cfg_weight = 16'h1111;
    abus_mreq  = 4'b0011;
    seen       = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (abus_tabort || abus_mgrant !== 4'b0001) seen = 1'b1;
      abus_sack = (k == 7);
      tick();
    end
    abus_sack = 1'b0;
    total_cnt++;
    if (seen)
      $display("FAIL simul_hold: grant/abort disturbed before ack, got 1 want 0");
    else pass_cnt++;
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq} !== 6'b0010_00)
      $display("FAIL simul_rotate: got g=%b ab=%b irq=%b want 0010/0/0",
               abus_mgrant, abus_tabort, timeout_irq);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq} !== 6'b0010_00)
      $display("FAIL simul_noirq: got g=%b ab=%b irq=%b want 0010/0/0",
               abus_mgrant, abus_tabort, timeout_irq);
    else pass_cnt++;
    abus_mreq = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    cfg_weight = 16'h1111;
    abus_mreq  = 4'b0011;
    tick();
    total_cnt++;
    if (abus_mgrant !== 4'b0001)
      $display("FAIL withdraw_first: got %b want 0001", abus_mgrant);
    else pass_cnt++;
    abus_mreq = 4'b0010;
    tick();
    total_cnt++;
    if (abus_mgrant !== 4'b0000)
      $display("FAIL withdraw_drop: got %b want 0000", abus_mgrant);
    else pass_cnt++;
    abus_mreq = 4'b0011;
    tick();
    total_cnt++;
    if (abus_mgrant !== 4'b0010)
      $display("FAIL withdraw_ptr: got %b want 0010", abus_mgrant);
    else pass_cnt++;
    abus_mreq = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_weight = 16'h1111;
    abus_mreq  = 4'b0100;
    tick();
    repeat (9) tick();
    abus_mreq = 4'b0010;
    tick();
    total_cnt++;
    if ({abus_mgrant, timeout_mid} !== 7'b0010_010)
      $display("FAIL rstmid_pre: got g=%b mid=%0d want 0010/2",
               abus_mgrant, timeout_mid);
    else pass_cnt++;
    tick();
    #2;
    abus_rstb = 1'b0;
    #1;
    total_cnt++;
    if ({abus_mgrant, abus_tabort, timeout_irq, timeout_mid} !== 9'b0)
      $display("FAIL rstmid_async: got g=%b ab=%b irq=%b mid=%0d want 0/0/0/0",
               abus_mgrant, abus_tabort, timeout_irq, timeout_mid);
    else pass_cnt++;
    tick();
    abus_rstb = 1'b1;
    abus_mreq = 4'b1011;
    tick();
    total_cnt++;
    if ({abus_mgrant, abus_tabort} !== 5'b0001_0)
      $display("FAIL rstmid_m0_first: got g=%b ab=%b want 0001/0",
               abus_mgrant, abus_tabort);
    else pass_cnt++;
    abus_mreq = '0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_weight();
    test_timeout();
    test_simul();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
